// File: rtl/proc_ctrl_pkg.sv
// Shared definitions for the reset/error supervisor.
// Contents:
//   state_t          supervisor FSM states
//   status_t         terminal status code, also used for reporting
//   RST_CYCLES_DEF   default core reset stretch length
//   MAX_CYCLES_DEF   default run-cycle limit (0 would disable it)
//   flags_to_status  folds the three sticky flags into one status code
package proc_ctrl_pkg;

  localparam int unsigned RST_CYCLES_DEF = 4;
  localparam int unsigned MAX_CYCLES_DEF = 100000;

  typedef enum logic [2:0] {
    S_RESET,
    S_RUN,
    S_ERROR,
    S_HALTED,
    S_TIMEOUT
  } state_t;

  typedef enum logic [1:0] {
    ST_NONE,
    ST_ERR,
    ST_HALT,
    ST_TIMEOUT
  } status_t;

  // Only one sticky flag can ever be set, so the order of the tests
  // here does not matter for a legal flag combination.
  function automatic status_t flags_to_status(input logic err_seen,
                                              input logic halted,
                                              input logic timeout);
    status_t s;
    s = ST_NONE;
    if (err_seen)     s = ST_ERR;
    else if (halted)  s = ST_HALT;
    else if (timeout) s = ST_TIMEOUT;
    return s;
  endfunction

endpackage

// File: rtl/rst_err_ctrl_if.sv
// Signal bundle between the processor core side and the supervisor.
// Ports:
//   err, halt          core status flags into the supervisor
//   proc_rst           stretched core reset out of the supervisor
//   cycle_count        completed run cycles
//   err_seen, halted,
//   timeout, done      sticky terminal status
// Modports:
//   master  core / bench side (drives err, halt)
//   slave   supervisor side (drives everything else)
interface rst_err_ctrl_if #(
  parameter int unsigned CYC_W = 32
);

  logic             err;
  logic             halt;
  logic             proc_rst;
  logic [CYC_W-1:0] cycle_count;
  logic             err_seen;
  logic             halted;
  logic             timeout;
  logic             done;

  modport master (
    output err, halt,
    input  proc_rst, cycle_count, err_seen, halted, timeout, done
  );

  modport slave (
    input  err, halt,
    output proc_rst, cycle_count, err_seen, halted, timeout, done
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and optional saturation.
// Ports:
//   clk       clock, rising edge
//   clr       synchronous clear to zero, highest priority
//   en        count enable
//   saturate  1: hold at all-ones, 0: wrap to zero
//   count     current value
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic         saturate,
  output logic [W-1:0] count
);

  logic at_max;

  assign at_max = &count;

  always_ff @(posedge clk) begin
    if (clr) begin
      count <= '0;
    end else if (en && !(saturate && at_max)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/rst_err_ctrl.sv
// Reset/error supervisor sitting between the clock/reset source and the core.
// Stretches the raw reset into a minimum-length core reset, counts run
// cycles and latches the first terminal event (error, halt or timeout).
// Ports:
//   clk   clock, rising edge
//   rst   synchronous active-high reset
//   bus   slave side of rst_err_ctrl_if (err/halt in, status out)
// All outputs are registered.
module rst_err_ctrl
  import proc_ctrl_pkg::*;
#(
  parameter int unsigned RST_CYCLES = RST_CYCLES_DEF,
  parameter int unsigned CYC_W      = 32,
  parameter int unsigned MAX_CYCLES = MAX_CYCLES_DEF
) (
  input logic           clk,
  input logic           rst,
  rst_err_ctrl_if.slave bus
);

  localparam int unsigned SW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [SW-1:0] STRETCH_INIT = SW'(RST_CYCLES - 1);
  localparam bit LIMIT_ON = (MAX_CYCLES != 0);
  // Timeout fires when the count that is about to be incremented equals
  // MAX_CYCLES-1, so the frozen count ends at exactly MAX_CYCLES.
  localparam logic [CYC_W-1:0] LIMIT = CYC_W'((MAX_CYCLES == 0) ? 0 : MAX_CYCLES - 1);

  state_t        state, state_next;
  logic [SW-1:0] stretch, stretch_next;
  logic          proc_rst_q, proc_rst_next;
  logic          err_seen_q, err_seen_next;
  logic          halted_q, halted_next;
  logic          timeout_q, timeout_next;
  logic          done_q, done_next;
  logic          run_en;
  logic [CYC_W-1:0] count;

  sat_counter #(.W(CYC_W)) u_cycle_cnt (
    .clk      (clk),
    .clr      (rst),
    .en       (run_en),
    .saturate (1'b1),
    .count    (count)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_RESET;
      stretch    <= STRETCH_INIT;
      proc_rst_q <= 1'b1;
      err_seen_q <= 1'b0;
      halted_q   <= 1'b0;
      timeout_q  <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state      <= state_next;
      stretch    <= stretch_next;
      proc_rst_q <= proc_rst_next;
      err_seen_q <= err_seen_next;
      halted_q   <= halted_next;
      timeout_q  <= timeout_next;
      done_q     <= done_next;
    end
  end

  // proc_rst drops on the same edge that moves RESET to RUN, giving
  // exactly RST_CYCLES high cycles after the last rst cycle.
  // err beats halt beats timeout when several hit the same RUN cycle.
  always_comb begin
    state_next    = state;
    stretch_next  = stretch;
    proc_rst_next = 1'b0;
    err_seen_next = err_seen_q;
    halted_next   = halted_q;
    timeout_next  = timeout_q;
    run_en        = 1'b0;

    case (state)
      S_RESET: begin
        proc_rst_next = 1'b1;
        if (stretch == '0) begin
          state_next    = S_RUN;
          proc_rst_next = 1'b0;
        end else begin
          stretch_next = stretch - SW'(1);
        end
      end
      S_RUN: begin
        run_en = 1'b1;
        if (bus.err) begin
          state_next    = S_ERROR;
          err_seen_next = 1'b1;
        end else if (bus.halt) begin
          state_next  = S_HALTED;
          halted_next = 1'b1;
        end else if (LIMIT_ON && (count == LIMIT)) begin
          state_next   = S_TIMEOUT;
          timeout_next = 1'b1;
        end
      end
      S_ERROR, S_HALTED, S_TIMEOUT: begin
      end
      default: begin
        state_next = S_RESET;
      end
    endcase

    done_next = err_seen_next | halted_next | timeout_next;
  end

  assign bus.proc_rst    = proc_rst_q;
  assign bus.cycle_count = count;
  assign bus.err_seen    = err_seen_q;
  assign bus.halted      = halted_q;
  assign bus.timeout     = timeout_q;
  assign bus.done        = done_q;

endmodule

// File: doc/rst_err_ctrl.md
Name: rst_err_ctrl

Overview:
- Reset/error supervisor that sits directly upstream of the processor core, in the slot between the clock/reset source and `proc`.
- Takes the raw synchronous reset and stretches it into a clean, minimum-length core reset (`proc_rst`).
- Counts run cycles and watches the core's `err` and `halt` outputs.
- Latches a sticky terminal status (error, halt, timeout) for the bench and top level to sample.

Parameters:
- RST_CYCLES, 4: number of cycles `proc_rst` stays asserted after `rst` deasserts; legal range ≥1.
- CYC_W, 32: width of the run-cycle counter.
- MAX_CYCLES, 100000: run-cycle limit that triggers timeout; 0 disables the limit.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- err  in  1  error flag from the core, sampled every cycle.
- halt  in  1  halt-instruction-retired flag from the core.
- proc_rst  out  1  stretched synchronous reset to the core, active high.
- cycle_count  out  CYC_W  number of completed RUN cycles.
- err_seen  out  1  sticky: terminated on `err`.
- halted  out  1  sticky: terminated on `halt`.
- timeout  out  1  sticky: terminated on MAX_CYCLES.
- done  out  1  OR of the three sticky flags.

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- All outputs are registered. None are combinational from inputs.
- States: RESET, RUN, ERROR, HALTED, TIMEOUT. State encoding lives in the shared package.
- Reset values while `rst`=1:
  - state=RESET, stretch counter=RST_CYCLES-1, proc_rst=1.
  - cycle_count=0.
  - err_seen=halted=timeout=done=0.
- RESET:
  - proc_rst=1 throughout.
  - The stretch counter decrements each cycle `rst`=0.
  - When the counter is 0 and `rst`=0, the next state is RUN and `proc_rst` drops on that same edge.
  - Result: `proc_rst` stays high for exactly RST_CYCLES cycles after the last `rst`=1 cycle.
  - `err` and `halt` are ignored in RESET.
- RUN:
  - proc_rst=0.
  - cycle_count increments by 1 every RUN cycle, saturating at all-ones (no wrap).
  - Transition priority, evaluated on the sampled inputs:
    1. err=1 → ERROR; err_seen=1 and done=1 on the following edge.
    2. halt=1 → HALTED; halted=1 and done=1.
    3. MAX_CYCLES≠0 and cycle_count == MAX_CYCLES-1 → TIMEOUT; timeout=1 and done=1.
  - err and halt in the same cycle → ERROR only; halted stays 0.
  - cycle_count still increments on the terminating cycle.
- Terminal states (ERROR/HALTED/TIMEOUT):
  - Sticky until `rst`.
  - cycle_count frozen, proc_rst=0.
  - Further err/halt have no effect; exactly one sticky flag is ever set.
- `rst` mid-operation, in any state: next edge returns everything to the reset values and restarts the stretch.
- Latency:
  - err/halt sampled at edge N → flag visible after edge N.
  - `done` rises in the same cycle as the flag.

Decomposition:
- Package `proc_ctrl_pkg` holds:
  - the state enum;
  - default constants RST_CYCLES_DEF and MAX_CYCLES_DEF;
  - a status-code typedef {NONE, ERR, HALT, TIMEOUT} that the bench reuses for reporting.
- One sub-module, `sat_counter` (parameterised width, enable, sync clear, saturate flag), is used for cycle_count.
- The stretch counter is small and stays inline.

Test Plan:
- Reset stretch: RST_CYCLES=4, hold `rst` for 3 cycles then release → proc_rst=1 for exactly 4 more cycles, then 0; cycle_count=0 on the first RUN cycle and 1 after it.
- Halt: after 10 RUN cycles, pulse halt=1 for one cycle → halted=1, done=1, err_seen=0; cycle_count=11 and stays at 11 for 20 further cycles.
- Error priority: raise err=1 and halt=1 in the same RUN cycle → err_seen=1, halted=0, state ERROR; a later err pulse changes nothing.
- Timeout: MAX_CYCLES=16, no err/halt → timeout=1 after the 16th RUN cycle; cycle_count=16 frozen. Repeat with MAX_CYCLES=0 for 1000 cycles → timeout never asserts.
- Ignore during reset: pulse err=1 and halt=1 while proc_rst=1 → no flags set, RUN entered normally.
- Reset mid-run and saturation:
  - assert `rst` for 1 cycle at run cycle 50 → all flags 0, cycle_count=0, 4-cycle stretch restarts;
  - separately, CYC_W=4 with MAX_CYCLES=0 → cycle_count saturates at 15 with no wrap.
